bht_port_arbiter: RTL and testbench

Scheduler for the shared single-port branch history table (BHT) used by the predictor. Arbitrates each cycle between IF-stage prediction lookups and ROB branch-outcome feedback, buffers feedback in a small update FIFO, and performs 2-bit saturating-counter read-modify-write on drain. Sits between IF/predictor (lookup side) and ROB (commit feedback side). Flushes lookups on misprediction; committed updates are never dropped.

---
 rtl/bht_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_bht_port_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bht_port_arbiter.sv
// Single-port BHT scheduler: arbitrates IF lookups against ROB outcome feedback,
// buffering feedback in a small FIFO drained by 2-bit saturating-counter RMW.
module bht_port_arbiter #(
    parameter int unsigned IDX_W      = 8,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       lookup_valid,
    input  logic [IDX_W-1:0]           lookup_idx,
    output logic                       lookup_ready,
    output logic                       resp_valid,
    output logic                       resp_taken,
    input  logic                       upd_valid,
    input  logic [IDX_W-1:0]           upd_idx,
    input  logic                       upd_taken,
    output logic                       upd_ready,
    input  logic                       jump_wrong,
    output logic [$clog2(DEPTH+1)-1:0] upd_pending
);

    localparam int unsigned ENTRIES = 2 ** IDX_W;
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned ST_W    = $clog2(STARVE_MAX + 1);

    logic [1:0]       bht_q [ENTRIES];
    logic [1:0]       bht_d [ENTRIES];
    logic [IDX_W-1:0] fifo_idx_q [DEPTH];
    logic [IDX_W-1:0] fifo_idx_d [DEPTH];
    logic [DEPTH-1:0] fifo_tk_q, fifo_tk_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ST_W-1:0]  starve_q, starve_d;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_taken_q, resp_taken_d;

    logic             full, nonempty, starved;
    logic             grant, drain, push;
    logic [IDX_W-1:0] head_idx;
    logic             head_taken;
    logic [1:0]       head_cnt, head_cnt_new;

    assign full       = (cnt_q == DEPTH[CNT_W-1:0]);
    assign nonempty   = (cnt_q != '0);
    assign starved    = (starve_q == STARVE_MAX[ST_W-1:0]);
    assign head_idx   = fifo_idx_q[rd_ptr_q];
    assign head_taken = fifo_tk_q[rd_ptr_q];
    assign head_cnt   = bht_q[head_idx];

    always_comb begin
        if (head_taken) begin
            head_cnt_new = (head_cnt == 2'b11) ? 2'b11 : head_cnt + 2'b01;
        end else begin
            head_cnt_new = (head_cnt == 2'b00) ? 2'b00 : head_cnt - 2'b01;
        end
    end

    // Single array port: a cycle grants either the lookup or the head drain, never both.
    always_comb begin
        grant = 1'b0;
        drain = 1'b0;
        if (rdy) begin
            if (jump_wrong) begin
                drain = nonempty;
            end else if (full || starved) begin
                drain = nonempty;
            end else if (lookup_valid) begin
                grant = 1'b1;
            end else begin
                drain = nonempty;
            end
        end
    end

    assign push         = rdy && upd_valid && !full;
    assign lookup_ready = grant;
    assign upd_ready    = rdy && !full;
    assign upd_pending  = cnt_q;
    assign resp_valid   = resp_valid_q;
    assign resp_taken   = resp_taken_q;

    always_comb begin
        bht_d        = bht_q;
        fifo_idx_d   = fifo_idx_q;
        fifo_tk_d    = fifo_tk_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        starve_d     = starve_q;
        resp_valid_d = resp_valid_q;
        resp_taken_d = resp_taken_q;

        if (push) begin
            fifo_idx_d[wr_ptr_q] = upd_idx;
            fifo_tk_d[wr_ptr_q]  = upd_taken;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (drain) begin
            bht_d[head_idx] = head_cnt_new;
            rd_ptr_d        = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, drain})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        if (rdy) begin
            if (drain || !nonempty) begin
                starve_d = '0;
            end else if (grant) begin
                starve_d = starve_q + ST_W'(1);
            end
            resp_valid_d = grant;
            if (grant) begin
                resp_taken_d = bht_q[lookup_idx][1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht_q[i] <= 2'b01;
            end
            for (int i = 0; i < DEPTH; i++) begin
                fifo_idx_q[i] <= '0;
            end
            fifo_tk_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            starve_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_taken_q <= 1'b0;
        end else begin
            bht_q        <= bht_d;
            fifo_idx_q   <= fifo_idx_d;
            fifo_tk_q    <= fifo_tk_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            starve_q     <= starve_d;
            resp_valid_q <= resp_valid_d;
            resp_taken_q <= resp_taken_d;
        end
    end

endmodule

// File: tb/tb_bht_port_arbiter.sv
// Scoreboard bench for bht_port_arbiter: directed arbitration scenarios plus a
// per-index counter model whose predictions are queued at lookup acceptance.
module tb_bht_port_arbiter;

    localparam int unsigned IDX_W  = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned STARVE = 3;

    logic             clk = 1'b0;
    logic             rst, rdy;
    logic             lookup_valid, lookup_ready, resp_valid, resp_taken;
    logic [IDX_W-1:0] lookup_idx, upd_idx;
    logic             upd_valid, upd_taken, upd_ready, jump_wrong;
    logic [2:0]       upd_pending;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] model [2**IDX_W];
    logic       exp_q [$];
    logic       rdy_seen = 1'b1;

    bht_port_arbiter #(
        .IDX_W      (IDX_W),
        .DEPTH      (DEPTH),
        .STARVE_MAX (STARVE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .lookup_valid (lookup_valid),
        .lookup_idx   (lookup_idx),
        .lookup_ready (lookup_ready),
        .resp_valid   (resp_valid),
        .resp_taken   (resp_taken),
        .upd_valid    (upd_valid),
        .upd_idx      (upd_idx),
        .upd_taken    (upd_taken),
        .upd_ready    (upd_ready),
        .jump_wrong   (jump_wrong),
        .upd_pending  (upd_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: responses are popped when they appear, predictions pushed on acceptance.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            for (int i = 0; i < 2**IDX_W; i++) model[i] = 2'b01;
            rdy_seen = 1'b1;
        end else begin
            if (resp_valid && rdy_seen) begin
                if (exp_q.size() == 0) begin
                    check("resp_spurious", 1, 0);
                end else begin
                    check("resp_taken", int'(resp_taken), int'(exp_q.pop_front()));
                end
            end
            if (lookup_valid && lookup_ready) exp_q.push_back(model[lookup_idx][1]);
            if (upd_valid && upd_ready) begin
                if (upd_taken) model[upd_idx] = (model[upd_idx] == 2'b11) ? 2'b11 : model[upd_idx] + 2'b01;
                else           model[upd_idx] = (model[upd_idx] == 2'b00) ? 2'b00 : model[upd_idx] - 2'b01;
            end
            rdy_seen = rdy;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_lookup(input int idx);
        lookup_valid = 1'b1;
        lookup_idx   = IDX_W'(idx);
        @(negedge clk);
        check("lk_ready", int'(lookup_ready), 1);
        next_cycle();
        lookup_valid = 1'b0;
        @(negedge clk);
        check("lk_resp_valid", int'(resp_valid), 1);
        next_cycle();
    endtask

    task automatic push(input int idx, input logic tk);
        upd_valid = 1'b1;
        upd_idx   = IDX_W'(idx);
        upd_taken = tk;
        @(negedge clk);
        check("push_ready", int'(upd_ready), 1);
        next_cycle();
        upd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        @(negedge clk);
        while (upd_pending != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", int'(upd_pending), 0);
        next_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int exp_lk [4];
        exp_lk = '{1, 1, 1, 0};
        rst = 1'b0; rdy = 1'b1; lookup_valid = 1'b0; lookup_idx = '0;
        upd_valid = 1'b0; upd_idx = '0; upd_taken = 1'b0; jump_wrong = 1'b0;
        repeat (2) next_cycle();
        @(negedge clk);
        check("rst_resp_valid", int'(resp_valid), 0);
        check("rst_resp_taken", int'(resp_taken), 0);
        check("rst_pending", int'(upd_pending), 0);
        next_cycle();
        rst = 1'b1;
        next_cycle();

        // Counter behaviour on a single index
        do_lookup(5);
        check("t1_pending", int'(upd_pending), 0);
        push(5, 1'b1); push(5, 1'b1);
        repeat (3) next_cycle();
        wait_drain();
        do_lookup(5);
        push(5, 1'b1); push(5, 1'b0);
        wait_drain();
        do_lookup(5);
        repeat (4) push(5, 1'b0);
        wait_drain();
        do_lookup(5);

        // FIFO fills under continuous lookups, then forced drain
        lookup_valid = 1'b1; lookup_idx = 8'd100;
        for (int i = 0; i < 4; i++) begin
            upd_valid = 1'b1; upd_idx = IDX_W'(10 + i); upd_taken = 1'b1;
            @(negedge clk);
            check("full_lk_ready", int'(lookup_ready), 1);
            check("full_upd_ready", int'(upd_ready), 1);
            next_cycle();
        end
        upd_valid = 1'b0;
        @(negedge clk);
        check("full_pending", int'(upd_pending), 4);
        check("full_upd_ready0", int'(upd_ready), 0);
        check("full_lk_ready0", int'(lookup_ready), 0);
        next_cycle();
        @(negedge clk);
        check("full_pending3", int'(upd_pending), 3);
        check("full_lk_again", int'(lookup_ready), 1);
        next_cycle();
        lookup_valid = 1'b0;
        wait_drain();
        for (int i = 0; i < 4; i++) do_lookup(10 + i);

        // Starvation bound
        push(20, 1'b1);
        lookup_valid = 1'b1; lookup_idx = 8'd101;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("starve_lk_ready", int'(lookup_ready), exp_lk[i]);
            check("starve_pending", int'(upd_pending), 1);
            next_cycle();
        end
        @(negedge clk);
        check("starve_drained", int'(upd_pending), 0);
        check("starve_lk_back", int'(lookup_ready), 1);
        next_cycle();
        lookup_valid = 1'b0;
        next_cycle();
        do_lookup(20);

        // Misprediction flush blocks lookup, drain proceeds
        push(21, 1'b1);
        lookup_valid = 1'b1; lookup_idx = 8'd102; jump_wrong = 1'b1;
        @(negedge clk);
        check("jw_lk_ready", int'(lookup_ready), 0);
        check("jw_pending", int'(upd_pending), 1);
        next_cycle();
        lookup_valid = 1'b0; jump_wrong = 1'b0;
        @(negedge clk);
        check("jw_resp_valid", int'(resp_valid), 0);
        check("jw_pending0", int'(upd_pending), 0);
        next_cycle();

        // Asynchronous reset with pending entries
        lookup_valid = 1'b1; lookup_idx = 8'd10;
        push(40, 1'b1);
        push(41, 1'b1);
        lookup_valid = 1'b0;
        check("pre_rst_pending", int'(upd_pending), 2);
        check("pre_rst_taken", int'(resp_taken), 1);
        #2 rst = 1'b0;
        #1;
        check("async_resp_valid", int'(resp_valid), 0);
        check("async_resp_taken", int'(resp_taken), 0);
        check("async_pending", int'(upd_pending), 0);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        do_lookup(10);
        do_lookup(40);

        // rdy low freezes everything
        lookup_valid = 1'b1; lookup_idx = 8'd103;
        push(50, 1'b1);
        push(51, 1'b1);
        rdy = 1'b0; upd_valid = 1'b1; upd_idx = 8'd52; upd_taken = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_pending", int'(upd_pending), 2);
            check("hold_lk_ready", int'(lookup_ready), 0);
            check("hold_upd_ready", int'(upd_ready), 0);
            check("hold_resp_valid", int'(resp_valid), 1);
            next_cycle();
        end
        rdy = 1'b1; upd_valid = 1'b0; lookup_valid = 1'b0;
        wait_drain();
        do_lookup(50);
        do_lookup(51);
        do_lookup(52);

        @(negedge clk);
        check("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
